spi_master_multi: RTL and testbench

//   Parametrised SPI master: one transfer of DATA_W bits per start pulse, any of
//   the 4 modes (CPOL/CPHA), SCK divided from clk, one-hot active-low chip

---
 rtl/spi_master_multi.sv | 167 ++++++++++++++++
 tb/tb_spi_master_multi.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// SPI master: one DATA_W-bit transfer per start, CPOL/CPHA per transfer, one-hot active-low chip selects.
// Latency: start accepted at edge N -> done pulse after edge N+(2*DATA_W+2)*CLK_DIV.
// Backpressure: none; start is ignored while busy, a start with an out-of-range cs_sel gets a 1-cycle err.
module spi_master_multi #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 2,
  parameter int LSB_FIRST = 0,
  localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rx_data
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW  = $clog2(DATA_W) + 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  BITS     = BCW'(DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state;
  logic [DIVW-1:0]   div_cnt;   // clk cycles within the current SCK half-period
  logic [BCW-1:0]    bit_cnt;   // bits sampled so far
  logic              lead;      // next SCK toggle is the leading edge
  logic              cpol_q;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sr;     // bits still to be driven, next one at the head
  logic [DATA_W-1:0] rx_sr;

  logic              tick;
  logic              sel_ok;
  logic [NUM_CS-1:0] cs_dec;
  logic              first_bit;
  logic              next_bit;
  logic [DATA_W-1:0] tx_data_adv;
  logic [DATA_W-1:0] tx_sr_adv;
  logic [DATA_W-1:0] rx_sr_in;

  // Divider tick, select decode and bit-order dependent head/shift views of the shift registers
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    sel_ok = (int'(cs_sel) < NUM_CS);
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_dec[i] = (int'(cs_sel) != i);
    end
    if (LSB_FIRST != 0) begin
      first_bit   = tx_data[0];
      tx_data_adv = tx_data >> 1;
      next_bit    = tx_sr[0];
      tx_sr_adv   = tx_sr >> 1;
      rx_sr_in    = {miso, rx_sr[DATA_W-1:1]};
    end else begin
      first_bit   = tx_data[DATA_W-1];
      tx_data_adv = tx_data << 1;
      next_bit    = tx_sr[DATA_W-1];
      tx_sr_adv   = tx_sr << 1;
      rx_sr_in    = {rx_sr[DATA_W-2:0], miso};
    end
  end

  // Transfer sequencer: IDLE -> SETUP -> XFER -> HOLD -> IDLE, all outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rx_data <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      lead    <= 1'b1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          sck     <= cpol;
          mosi    <= 1'b0;
          cs_n    <= '1;
          busy    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          lead    <= 1'b1;
          if (start && sel_ok) begin
            state  <= SETUP;
            cpol_q <= cpol;
            cpha_q <= cpha;
            cs_n   <= cs_dec;
            busy   <= 1'b1;
            // CPHA=0 slaves sample on the very first edge, so the first bit goes out with CS
            if (!cpha) begin
              mosi  <= first_bit;
              tx_sr <= tx_data_adv;
            end else begin
              tx_sr <= tx_data;
            end
          end else if (start) begin
            err <= 1'b1;
          end
        end

        // SETUP is the CS-to-first-edge lead; its final tick doubles as the first SCK edge
        SETUP, XFER: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (bit_cnt == BITS && lead) begin
              state <= HOLD;
            end else begin
              state <= XFER;
              sck   <= ~sck;
              lead  <= ~lead;
              if (lead ^ cpha_q) begin
                rx_sr   <= rx_sr_in;
                bit_cnt <= bit_cnt + 1'b1;
              end else if (bit_cnt != BITS) begin
                // after the final bit mosi keeps its value through HOLD
                mosi  <= next_bit;
                tx_sr <= tx_sr_adv;
              end
            end
          end
        end

        HOLD: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            state   <= IDLE;
            mosi    <= 1'b0;
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: three instances (defaults, 3 selects, LSB-first 8-bit CLK_DIV=1).
// Expected done words and done cycles are queued by the stimulus and consumed by a monitor.
// Direct point checks are also queued so the monitor is the only place that counts results.
module tb_spi_master_multi;

  localparam int LAT0 = (2 * 16 + 2) * 4;
  localparam int LAT2 = (2 * 8 + 2) * 1;

  typedef struct {
    logic [15:0] rx;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: defaults
  logic        start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0;
  logic [0:0]  sel0 = '0;
  logic [15:0] tx0 = '0;
  logic        miso0, sck0, mosi0, busy0, done0, err0;
  logic [1:0]  cs_n0;
  logic [15:0] rx0;

  // instance 1: three chip selects
  logic        start1 = 1'b0, cpol1 = 1'b0, cpha1 = 1'b0;
  logic [1:0]  sel1 = '0;
  logic [15:0] tx1 = '0;
  logic        miso1, sck1, mosi1, busy1, done1, err1;
  logic [2:0]  cs_n1;
  logic [15:0] rx1;

  // instance 2: LSB first, 8 bits, CLK_DIV=1
  logic        start2 = 1'b0, cpol2 = 1'b0, cpha2 = 1'b0;
  logic [0:0]  sel2 = '0;
  logic [7:0]  tx2 = '0;
  logic        miso2, sck2, mosi2, busy2, done2, err2;
  logic [1:0]  cs_n2;
  logic [7:0]  rx2;

  logic        loop0 = 1'b1;
  logic        slv_miso = 1'b0;
  logic [15:0] slv_word = 16'hA5C3;
  logic [3:0]  slv_idx = 4'd15;
  logic [15:0] slv_rx = '0;

  assign miso0 = loop0 ? mosi0 : slv_miso;
  assign miso1 = mosi1;
  assign miso2 = mosi2;

  spi_master_multi u0 (
    .clk(clk), .rst(rst), .start(start0), .cpol(cpol0), .cpha(cpha0), .cs_sel(sel0),
    .tx_data(tx0), .miso(miso0), .sck(sck0), .mosi(mosi0), .cs_n(cs_n0), .busy(busy0),
    .done(done0), .err(err0), .rx_data(rx0)
  );

  spi_master_multi #(.NUM_CS(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .cpol(cpol1), .cpha(cpha1), .cs_sel(sel1),
    .tx_data(tx1), .miso(miso1), .sck(sck1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1),
    .done(done1), .err(err1), .rx_data(rx1)
  );

  spi_master_multi #(.DATA_W(8), .CLK_DIV(1), .LSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .cpol(cpol2), .cpha(cpha2), .cs_sel(sel2),
    .tx_data(tx2), .miso(miso2), .sck(sck2), .mosi(mosi2), .cs_n(cs_n2), .busy(busy2),
    .done(done2), .err(err2), .rx_data(rx2)
  );

  // SPI slave on select 0 of instance 0: drives MSB first on falling SCK, captures mosi on rising SCK
  always @(negedge sck0 or posedge cs_n0[0]) begin
    if (cs_n0[0]) begin
      slv_idx <= 4'd15;
    end else begin
      slv_miso <= slv_word[slv_idx];
      slv_idx  <= slv_idx - 4'd1;
    end
  end

  always @(posedge sck0) begin
    if (!cs_n0[0]) slv_rx <= {slv_rx[14:0], mosi0};
  end

  exp_t exp0_q[$];
  exp_t exp1_q[$];
  exp_t exp2_q[$];
  chk_t chk_q[$];

  int checks = 0;
  int errors = 0;
  int rises0 = 0;
  int mosi_bad0 = 0;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  // Monitor: sole owner of the counters; consumes queued point checks and every done pulse
  initial begin
    chk_t       r;
    exp_t       e;
    logic       p_sck  = 1'b0;
    logic       p_mosi = 1'b0;
    logic [1:0] p_csn  = 2'b11;
    forever begin
      @(negedge clk);
      while (chk_q.size() != 0) begin
        r = chk_q.pop_front();
        cmp(r.name, r.act, r.exp);
      end
      if (done0) begin
        if (exp0_q.size() == 0) cmp("done0_unexpected", 1, 0);
        else begin
          e = exp0_q.pop_front();
          cmp("done0_rx", 32'(rx0), 32'(e.rx));
          cmp("done0_cycle", cyc, e.cyc);
        end
      end
      if (done1) begin
        if (exp1_q.size() == 0) cmp("done1_unexpected", 1, 0);
        else begin
          e = exp1_q.pop_front();
          cmp("done1_rx", 32'(rx1), 32'(e.rx));
          cmp("done1_cycle", cyc, e.cyc);
        end
      end
      if (done2) begin
        if (exp2_q.size() == 0) cmp("done2_unexpected", 1, 0);
        else begin
          e = exp2_q.pop_front();
          cmp("done2_rx", 32'(rx2), 32'(e.rx));
          cmp("done2_cycle", cyc, e.cyc);
        end
      end
      if (p_csn == 2'b10 && cs_n0 == 2'b10) begin
        if (!p_sck && sck0) rises0++;
        if (mosi0 != p_mosi && !(p_sck && !sck0)) mosi_bad0++;
      end
      p_sck  = sck0;
      p_mosi = mosi0;
      p_csn  = cs_n0;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t r;
    r.name = n;
    r.act  = a;
    r.exp  = e;
    chk_q.push_back(r);
  endtask

  task automatic expect_done(input int which, input logic [15:0] rx, input int at);
    exp_t e;
    e.rx  = rx;
    e.cyc = at;
    case (which)
      0:       exp0_q.push_back(e);
      1:       exp1_q.push_back(e);
      default: exp2_q.push_back(e);
    endcase
  endtask

  // Start a transfer on instance 0; returns #1 after the accepting edge with inputs scrambled
  task automatic go0(input logic [15:0] tx, input logic sel, input logic p, input logic h,
                     input logic [15:0] exp_rx, input bit push);
    @(posedge clk); #1;
    start0 = 1'b1; tx0 = tx; sel0 = sel; cpol0 = p; cpha0 = h;
    if (push) expect_done(0, exp_rx, cyc + 1 + LAT0);
    @(posedge clk); #1;
    start0 = 1'b0; tx0 = ~tx; sel0 = ~sel; cpha0 = ~h;
  endtask

  // Step until done is visible (bounded); counts cycles with busy low on the way
  task automatic wait_done(input int which, output int gaps);
    logic d, b, got;
    gaps = 0;
    got  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      case (which)
        0:       begin d = done0; b = busy0; end
        1:       begin d = done1; b = busy1; end
        default: begin d = done2; b = busy2; end
      endcase
      if (d) begin
        got = 1'b1;
        break;
      end
      if (!b) gaps++;
      @(posedge clk); #1;
    end
    if (!got) chk($sformatf("done%0d_timeout", which), 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gaps, n, base;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", sck0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_cs_n", cs_n0, 2'b11);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_rx", rx0, 0);
    chk("rst_cs_n1", cs_n1, 3'b111);
    chk("rst_cs_n2", cs_n2, 2'b11);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: mode 0 loopback
    base = rises0;
    go0(16'h0407, 1'b0, 1'b0, 1'b0, 16'h0407, 1'b1);
    chk("t1_cs_n", cs_n0, 2'b10);
    chk("t1_busy", busy0, 1);
    wait_done(0, gaps);
    chk("t1_busy_gap", gaps, 0);
    chk("t1_sck_rises", rises0 - base, 16);
    chk("t1_cs_release", cs_n0, 2'b11);
    chk("t1_busy_drop", busy0, 0);

    // 2: mode 3 against the slave model
    loop0 = 1'b0; cpol0 = 1'b1; cpha0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_sck_idle", sck0, 1);
    base = mosi_bad0;
    go0(16'h3C5A, 1'b0, 1'b1, 1'b1, 16'hA5C3, 1'b1);
    wait_done(0, gaps);
    chk("t2_mosi_off_falling", mosi_bad0 - base, 0);
    chk("t2_slave_rx", slv_rx, 16'h3C5A);
    @(posedge clk); #1;
    chk("t2_sck_idle_after", sck0, 1);

    // 3: second start during a transfer is ignored
    loop0 = 1'b1;
    go0(16'hBEEF, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1);
    gaps = 0;
    for (int i = 0; i < 39; i++) begin
      @(posedge clk); #1;
      if (!busy0) gaps++;
    end
    start0 = 1'b1; tx0 = 16'h1234; sel0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("t3_cs_n_kept", cs_n0, 2'b10);
    wait_done(0, n);
    chk("t3_busy_gap", gaps + n, 0);

    // 4: reset mid-transfer, then a clean mode 1 transfer
    go0(16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_cs_n", cs_n0, 2'b11);
    chk("t4_sck", sck0, 0);
    chk("t4_busy", busy0, 0);
    chk("t4_mosi", mosi0, 0);
    chk("t4_rx", rx0, 0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("t4_rx_after_abort", rx0, 0);
    go0(16'h8001, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b1);
    wait_done(0, gaps);
    chk("t4_busy_gap", gaps, 0);

    // 5: NUM_CS=3, invalid select then select 2
    @(posedge clk); #1;
    start1 = 1'b1; sel1 = 2'd3; tx1 = 16'h1111;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("t5_err", err1, 1);
    chk("t5_cs_n", cs_n1, 3'b111);
    chk("t5_busy", busy1, 0);
    @(posedge clk); #1;
    chk("t5_err_pulse", err1, 0);
    chk("t5_busy_after", busy1, 0);
    start1 = 1'b1; sel1 = 2'd2; tx1 = 16'hC0DE;
    expect_done(1, 16'hC0DE, cyc + 1 + LAT0);
    @(posedge clk); #1;
    start1 = 1'b0; sel1 = 2'd0; tx1 = 16'h0000;
    chk("t5_cs_n_sel2", cs_n1, 3'b011);
    chk("t5_err_valid", err1, 0);
    wait_done(1, gaps);
    chk("t5_busy_gap", gaps, 0);

    // 6: LSB first, 8 bits, CLK_DIV=1, start held for a back-to-back pair
    @(posedge clk); #1;
    start2 = 1'b1; tx2 = 8'h01; sel2 = 1'b1;
    n = cyc + 1;
    expect_done(2, 16'h0001, n + LAT2);
    expect_done(2, 16'h00A6, n + LAT2 + 1 + LAT2);
    @(posedge clk); #1;
    chk("t6_first_bit", mosi2, 1);
    chk("t6_cs_n", cs_n2, 2'b01);
    tx2 = 8'hA6;
    @(posedge clk); #1;
    chk("t6_first_bit_held", mosi2, 1);
    @(posedge clk); #1;
    chk("t6_second_bit", mosi2, 0);
    repeat (16) @(posedge clk);
    #1;
    chk("t6_done", done2, 1);
    chk("t6_cs_gap", cs_n2, 2'b11);
    @(posedge clk); #1;
    chk("t6_cs_again", cs_n2, 2'b01);
    chk("t6_busy_again", busy2, 1);
    start2 = 1'b0; tx2 = 8'hFF;
    wait_done(2, gaps);
    chk("t6_busy_gap", gaps, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending0", exp0_q.size(), 0);
    chk("pending1", exp1_q.size(), 0);
    chk("pending2", exp2_q.size(), 0);
    @(negedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
